// File: rtl/regfile_mp.sv
// Multi-port register file: N_RD combinational read ports, two write ports (port 1 wins),
// optional write bypass and hardwired-zero entry, with a built-in clear sweep.
module regfile_mp #(
  parameter int unsigned BW_DATA  = 32,
  parameter int unsigned BW_ADDR  = 5,
  parameter int unsigned N_RD     = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      wen0,
  input  logic [BW_ADDR-1:0]        wr_addr0,
  input  logic [BW_DATA-1:0]        wr_data0,
  input  logic                      wen1,
  input  logic [BW_ADDR-1:0]        wr_addr1,
  input  logic [BW_DATA-1:0]        wr_data1,
  input  logic [N_RD*BW_ADDR-1:0]   rd_addr,
  output logic [N_RD*BW_DATA-1:0]   rd_data,
  output logic                      busy
);

  localparam int unsigned DEPTH = 2**BW_ADDR;

  typedef enum logic {StInit, StReady} state_e;

  state_e              state_q;
  logic [BW_ADDR-1:0]  cnt_q;
  logic                busy_q;
  logic [BW_DATA-1:0]  mem_q [DEPTH];

  logic wr_ok, we0, we1;

  assign wr_ok = (state_q == StReady) && !clr;
  assign we0   = wr_ok && wen0 && !(ZERO_REG && (wr_addr0 == '0));
  assign we1   = wr_ok && wen1 && !(ZERO_REG && (wr_addr1 == '0));
  assign busy  = busy_q;

  // A clr in either state restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (clr) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == StInit) begin
      if (&cnt_q) begin
        state_q <= StReady;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Storage has no reset; the sweep zeroes it. Port 1 is assigned last so it wins a collision.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [BW_ADDR-1:0] ra;
    logic [BW_DATA-1:0] rdat;

    assign ra = rd_addr[g*BW_ADDR +: BW_ADDR];

    always_comb begin
      rdat = mem_q[ra];
      if (busy_q) begin
        rdat = '0;
      end else if (ZERO_REG && (ra == '0)) begin
        rdat = '0;
      end else if (BYPASS && wr_ok && wen1 && (wr_addr1 == ra)) begin
        rdat = wr_data1;
      end else if (BYPASS && wr_ok && wen0 && (wr_addr0 == ra)) begin
        rdat = wr_data0;
      end
    end

    assign rd_data[g*BW_DATA +: BW_DATA] = rdat;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes model-predicted reads, monitor compares at negedge.
module tb_regfile_mp;

  localparam int unsigned BW_DATA  = 32;
  localparam int unsigned BW_ADDR  = 5;
  localparam int unsigned N_RD     = 4;
  localparam bit          ZERO_REG = 1'b1;
  localparam bit          BYPASS   = 1'b1;
  localparam int unsigned DEPTH    = 2**BW_ADDR;

  logic                    clk = 1'b0;
  logic                    rstn, clr, wen0, wen1;
  logic [BW_ADDR-1:0]      wr_addr0, wr_addr1;
  logic [BW_DATA-1:0]      wr_data0, wr_data1;
  logic [N_RD*BW_ADDR-1:0] rd_addr;
  logic [N_RD*BW_DATA-1:0] rd_data;
  logic                    busy;

  regfile_mp #(
    .BW_DATA (BW_DATA),
    .BW_ADDR (BW_ADDR),
    .N_RD    (N_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .wen0    (wen0),
    .wr_addr0(wr_addr0),
    .wr_data0(wr_data0),
    .wen1    (wen1),
    .wr_addr1(wr_addr1),
    .wr_data1(wr_data1),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                    busy;
    logic [N_RD*BW_DATA-1:0] data;
    int                      cyc;
  } exp_t;

  exp_t               exp_q[$];
  logic [BW_DATA-1:0] mdl [DEPTH];
  int                 sweep_left;
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_pass = 0;

  function automatic logic [BW_DATA-1:0] expect_read(input int a);
    bit ready_w;
    ready_w = (sweep_left == 0) && !clr && rstn;
    if (sweep_left > 0) return '0;
    if (ZERO_REG && a == 0) return '0;
    if (BYPASS && ready_w && wen1 && a == int'(wr_addr1)) return wr_data1;
    if (BYPASS && ready_w && wen0 && a == int'(wr_addr0)) return wr_data0;
    return mdl[a];
  endfunction

  task automatic model_clear();
    sweep_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  task automatic model_edge();
    if (!rstn) return;
    if (clr) begin
      model_clear();
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      if (wen0 && !(ZERO_REG && wr_addr0 == 0)) mdl[wr_addr0] = wr_data0;
      if (wen1 && !(ZERO_REG && wr_addr1 == 0)) mdl[wr_addr1] = wr_data1;
    end
  endtask

  task automatic step();
    exp_t e;
    e.busy = (sweep_left > 0);
    for (int i = 0; i < N_RD; i++)
      e.data[i*BW_DATA +: BW_DATA] = expect_read(int'(rd_addr[i*BW_ADDR +: BW_ADDR]));
    e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
  endtask

  task automatic set_rd(input int lane, input int a);
    rd_addr[lane*BW_ADDR +: BW_ADDR] = BW_ADDR'(a);
  endtask

  // Narrow address range half the time to provoke collisions and bypass hits.
  function automatic logic [BW_ADDR-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return BW_ADDR'($urandom_range(0, 7));
    return BW_ADDR'($urandom_range(0, DEPTH-1));
  endfunction

  task automatic rand_in(input int clr_pct);
    clr      = ($urandom_range(0, 99) < clr_pct);
    wen0     = $urandom_range(0, 1) == 1;
    wen1     = $urandom_range(0, 1) == 1;
    wr_addr0 = rand_addr();
    wr_addr1 = rand_addr();
    wr_data0 = $urandom;
    wr_data1 = $urandom;
    for (int i = 0; i < N_RD; i++) begin
      if ($urandom_range(0, 2) == 0) set_rd(i, int'(wr_addr1));
      else set_rd(i, int'(rand_addr()));
    end
  endtask

  task automatic rand_steps(input int n, input int clr_pct);
    for (int k = 0; k < n; k++) begin
      rand_in(clr_pct);
      step();
    end
    idle();
  endtask

  task automatic wr(input bit p, input int a, input logic [BW_DATA-1:0] d);
    if (p) begin wen1 = 1'b1; wr_addr1 = BW_ADDR'(a); wr_data1 = d; end
    else   begin wen0 = 1'b1; wr_addr0 = BW_ADDR'(a); wr_data0 = d; end
  endtask

  // Monitor: one popped prediction per cycle, sampled at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (busy === e.busy) n_pass++;
        else $display("FAIL busy cyc %0d got %b exp %b", e.cyc, busy, e.busy);
        for (int i = 0; i < N_RD; i++) begin
          n_checks++;
          if (rd_data[i*BW_DATA +: BW_DATA] === e.data[i*BW_DATA +: BW_DATA]) n_pass++;
          else $display("FAIL rd_lane%0d cyc %0d got %h exp %h", i, e.cyc,
                        rd_data[i*BW_DATA +: BW_DATA], e.data[i*BW_DATA +: BW_DATA]);
        end
      end
    end
  end

  initial begin
    rstn = 1'b1; idle();
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0; rd_addr = '0;
    model_clear();
    #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rstn = 1'b1;
    // Sweep after reset: writes attempted here must be lost.
    rand_steps(DEPTH + 3, 0);

    idle(); set_rd(0, 5); wr(0, 5, 32'hDEADBEEF); step();
    idle(); step();
    wr(0, 0, 32'h1); set_rd(1, 0); step();
    idle(); step();
    wr(0, 9, 32'hAAAA0000); wr(1, 9, 32'h5555FFFF); set_rd(2, 9); step();
    idle(); step();
    wr(0, 3, 32'h0303_0303); wr(1, 4, 32'h0404_0404); set_rd(0, 3); set_rd(1, 4); step();
    idle(); set_rd(2, 3); set_rd(3, 4); step();
    wr(1, 7, 32'h12345678); set_rd(1, 7); set_rd(0, 7); step();
    idle(); step();
    for (int i = 0; i < N_RD; i++) set_rd(i, 10 + i);
    wr(0, 10, 32'hA0); wr(1, 11, 32'hB1); step();
    idle(); wr(0, 12, 32'hC2); wr(1, 13, 32'hD3); step();
    idle(); step();

    rand_steps(400, 1);

    // Fill, clear, write during busy, re-pulse clr at sweep cycle 10.
    for (int a = 1; a < DEPTH; a += 2) begin
      idle(); wr(0, a, $urandom); if (a + 1 < DEPTH) wr(1, a + 1, $urandom); step();
    end
    idle(); clr = 1'b1; step();
    idle(); wr(0, 6, 32'hBAD0_0006); set_rd(0, 6); step();
    rand_steps(8, 0);
    idle(); clr = 1'b1; step();
    rand_steps(DEPTH + 5, 0);

    // Reset in the middle of a sweep.
    idle(); clr = 1'b1; step();
    rand_steps(14, 0);
    rstn = 1'b0;
    model_clear();
    step();
    rstn = 1'b1;
    rand_steps(DEPTH + 5, 0);

    rand_steps(200, 1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
